// File: rtl/opr_sequencer_pkg.sv
// Shared types and constants for the operate-microinstruction sequencer.
// State encoding, instruction bit positions and group codes live here.
package opr_sequencer_pkg;

    localparam int OPR_WORD_W = 12;

    typedef logic [OPR_WORD_W-1:0] opr_word_t;
    typedef logic [8:0]            opr_ir_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLR   = 4'd1,
        ST_CMP   = 4'd2,
        ST_INC   = 4'd3,
        ST_ROT1  = 4'd4,
        ST_ROT2  = 4'd5,
        ST_DONE  = 4'd6,
        ST_EVAL  = 4'd7,
        ST_G2CLR = 4'd8
    } opr_state_t;

    localparam logic [1:0] GRP_NONE = 2'd0;
    localparam logic [1:0] GRP_1    = 2'd1;
    localparam logic [1:0] GRP_2    = 2'd2;
    localparam logic [1:0] GRP_3    = 2'd3;

    localparam int IR_GRP = 8;
    localparam int IR_G3  = 0;

    localparam int G1_CLA = 7;
    localparam int G1_CLL = 6;
    localparam int G1_CMA = 5;
    localparam int G1_CML = 4;
    localparam int G1_RAR = 3;
    localparam int G1_RAL = 2;
    localparam int G1_BSW = 1;
    localparam int G1_IAC = 0;

    localparam int G2_CLA   = 7;
    localparam int G2_SMA   = 6;
    localparam int G2_SZA   = 5;
    localparam int G2_SNL   = 4;
    localparam int G2_SENSE = 3;

    function automatic logic [1:0] decode_group(input opr_ir_t ir);
        if (!ir[IR_GRP]) begin
            return GRP_1;
        end else if (!ir[IR_G3]) begin
            return GRP_2;
        end else begin
            return GRP_3;
        end
    endfunction

endpackage

// File: rtl/opr_rotate_unit.sv
// Combinational rotate/swap of the {L,AC} pair.
// Opposing rotate requests cancel; swap only applies with no rotate.
module opr_rotate_unit #(
    parameter int WORD_WIDTH = 12
) (
    input  logic                  i_rar,
    input  logic                  i_ral,
    input  logic                  i_bsw,
    input  logic                  i_l,
    input  logic [WORD_WIDTH-1:0] i_ac,
    output logic                  o_l,
    output logic [WORD_WIDTH-1:0] o_ac
);

    localparam int HALF = WORD_WIDTH / 2;

    // Select rotate right, rotate left, half-word swap or pass-through
    always_comb begin
        o_l  = i_l;
        o_ac = i_ac;
        if (i_rar && !i_ral) begin
            o_l  = i_ac[0];
            o_ac = {i_l, i_ac[WORD_WIDTH-1:1]};
        end else if (i_ral && !i_rar) begin
            o_l  = i_ac[WORD_WIDTH-1];
            o_ac = {i_ac[WORD_WIDTH-2:0], i_l};
        end else if (i_bsw && !i_rar && !i_ral) begin
            o_ac = {i_ac[HALF-1:0], i_ac[WORD_WIDTH-1:HALF]};
        end
    end

endmodule

// File: rtl/opr_sequencer.sv
// Multi-cycle sequencer for operate microinstructions, groups 1..3.
// Define OPR_BSW_EN to make group-1 bit 1 alone swap AC halves.
module opr_sequencer
    import opr_sequencer_pkg::*;
#(
    parameter int WORD_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8:0]            i_reg,
    input  logic [WORD_WIDTH-1:0] ac_in,
    input  logic                  l_in,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] ac_out,
    output logic                  l_out,
    output logic                  skip,
    output logic [1:0]            group
);

    opr_state_t            r_state;
    logic [7:0]            r_ir;
    logic [WORD_WIDTH-1:0] r_ac;
    logic                  r_l;
    logic                  r_skip;
    logic [1:0]            r_group;

    logic [1:0]            w_dec_grp;
    logic [WORD_WIDTH:0]   w_inc;
    logic                  w_bsw;
    logic                  w_rot_l;
    logic [WORD_WIDTH-1:0] w_rot_ac;
    logic                  w_msb;
    logic                  w_zero;
    logic                  w_skip;

    assign w_dec_grp = decode_group(i_reg);
    assign w_inc     = {r_l, r_ac} + {{WORD_WIDTH{1'b0}}, 1'b1};
    assign w_msb     = r_ac[WORD_WIDTH-1];
    assign w_zero    = (r_ac == '0);

`ifdef OPR_BSW_EN
    assign w_bsw = r_ir[G1_BSW] && (r_state == ST_ROT1);
`else
    assign w_bsw = 1'b0;
`endif

    opr_rotate_unit #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_rot (
        .i_rar (r_ir[G1_RAR]),
        .i_ral (r_ir[G1_RAL]),
        .i_bsw (w_bsw),
        .i_l   (r_l),
        .i_ac  (r_ac),
        .o_l   (w_rot_l),
        .o_ac  (w_rot_ac)
    );

    // Skip test on the pre-clear AC; sense inverts and ANDs the conditions
    always_comb begin
        w_skip = 1'b0;
        if (r_ir[G2_SENSE]) begin
            w_skip = (!r_ir[G2_SMA] || !w_msb)
                  && (!r_ir[G2_SZA] || !w_zero)
                  && (!r_ir[G2_SNL] || !r_l);
        end else begin
            w_skip = (r_ir[G2_SMA] && w_msb)
                  || (r_ir[G2_SZA] && w_zero)
                  || (r_ir[G2_SNL] && r_l);
        end
    end

    // State walk: one micro-step per cycle, path chosen by group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= (w_dec_grp == GRP_2) ? ST_EVAL : ST_CLR;
                    end
                end
                ST_CLR:   r_state <= (r_group == GRP_3) ? ST_DONE : ST_CMP;
                ST_CMP:   r_state <= ST_INC;
                ST_INC:   r_state <= ST_ROT1;
                ST_ROT1:  r_state <= ST_ROT2;
                ST_ROT2:  r_state <= ST_DONE;
                ST_EVAL:  r_state <= ST_G2CLR;
                ST_G2CLR: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: capture operands at start, apply each micro-op on exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir    <= '0;
            r_ac    <= '0;
            r_l     <= 1'b0;
            r_skip  <= 1'b0;
            r_group <= GRP_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ir    <= i_reg[7:0];
                        r_ac    <= ac_in;
                        r_l     <= l_in;
                        r_skip  <= 1'b0;
                        r_group <= w_dec_grp;
                    end
                end
                ST_CLR: begin
                    if (r_ir[G1_CLA]) begin
                        r_ac <= '0;
                    end
                    if (r_group == GRP_1 && r_ir[G1_CLL]) begin
                        r_l <= 1'b0;
                    end
                end
                ST_CMP: begin
                    if (r_ir[G1_CMA]) begin
                        r_ac <= ~r_ac;
                    end
                    if (r_ir[G1_CML]) begin
                        r_l <= ~r_l;
                    end
                end
                ST_INC: begin
                    if (r_ir[G1_IAC]) begin
                        {r_l, r_ac} <= w_inc;
                    end
                end
                ST_ROT1: begin
                    r_l  <= w_rot_l;
                    r_ac <= w_rot_ac;
                end
                ST_ROT2: begin
                    if (r_ir[G1_BSW]) begin
                        r_l  <= w_rot_l;
                        r_ac <= w_rot_ac;
                    end
                end
                ST_EVAL: begin
                    r_skip <= w_skip;
                end
                ST_G2CLR: begin
                    if (r_ir[G2_CLA]) begin
                        r_ac <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign ac_out = r_ac;
    assign l_out  = r_l;
    assign skip   = r_skip;
    assign group  = r_group;

endmodule

// File: tb/tb_opr_sequencer.sv
// Directed bench for opr_sequencer: latency, micro-ops, skip logic,
// reset abort and back-to-back starts.
module tb_opr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  i_reg;
    logic [11:0] ac_in;
    logic        l_in;
    logic        busy;
    logic        done;
    logic [11:0] ac_out;
    logic        l_out;
    logic        skip;
    logic [1:0]  group;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    opr_sequencer #(
        .WORD_WIDTH(12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .i_reg  (i_reg),
        .ac_in  (ac_in),
        .l_in   (l_in),
        .busy   (busy),
        .done   (done),
        .ac_out (ac_out),
        .l_out  (l_out),
        .skip   (skip),
        .group  (group)
    );

    // Pulse start for one cycle; report the cycle done appeared (-1 on
    // timeout) and whether done was still high one cycle later.
    task automatic run_op(input logic [8:0] ir, input logic [11:0] ac,
                          input logic l, output int dcyc, output logic dn);
        dcyc = -1;
        dn   = 1'b0;
        i_reg = ir;
        ac_in = ac;
        l_in  = l;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dcyc = k;
                break;
            end
        end
        @(posedge clk); #1;
        dn = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        i_reg = '0;
        ac_in = 12'o7777;
        l_in  = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if ({ac_out, l_out, skip, group} !== 16'h0) begin bad++; $display("FAIL rst_outs got ac=%o l=%b skip=%b grp=%0d want all 0", ac_out, l_out, skip, group); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_group1_iac();
        int d; logic dn;
        run_op(9'o001, 12'o7777, 1'b0, d, dn);
        total++; if (d !== 6) begin bad++; $display("FAIL iac_latency got=%0d want=6", d); end
        total++; if (dn !== 1'b0) begin bad++; $display("FAIL iac_done_width got=%b want=0", dn); end
        total++; if (ac_out !== 12'o0000) begin bad++; $display("FAIL iac_ac got=%o want=0000", ac_out); end
        total++; if (l_out !== 1'b1) begin bad++; $display("FAIL iac_l got=%b want=1", l_out); end
        total++; if (group !== 2'd1) begin bad++; $display("FAIL iac_group got=%0d want=1", group); end
        total++; if (skip !== 1'b0) begin bad++; $display("FAIL iac_skip got=%b want=0", skip); end
        @(posedge clk); #1;
        total++; if (ac_out !== 12'o0000 || l_out !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL iac_hold got ac=%o l=%b busy=%b want 0000/1/0", ac_out, l_out, busy); end
        run_op(9'o360, 12'o1234, 1'b0, d, dn);
        total++; if (ac_out !== 12'o7777 || l_out !== 1'b1) begin bad++; $display("FAIL clr_cmp got ac=%o l=%b want 7777/1", ac_out, l_out); end
        total++; if (d !== 6) begin bad++; $display("FAIL clr_cmp_latency got=%0d want=6", d); end
    endtask

    task automatic test_rotate();
        int d; logic dn;
        run_op(9'o006, 12'o0001, 1'b0, d, dn);
        total++; if (ac_out !== 12'o0004 || l_out !== 1'b0) begin bad++; $display("FAIL rtl got ac=%o l=%b want 0004/0", ac_out, l_out); end
        // AC bit 0 moves into L, then L moves into the AC msb
        run_op(9'o012, 12'o0001, 1'b0, d, dn);
        total++; if (ac_out !== 12'o4000 || l_out !== 1'b0) begin bad++; $display("FAIL rtr got ac=%o l=%b want 4000/0", ac_out, l_out); end
        total++; if (d !== 6) begin bad++; $display("FAIL rtr_latency got=%0d want=6", d); end
        run_op(9'o004, 12'o4000, 1'b0, d, dn);
        total++; if (ac_out !== 12'o0000 || l_out !== 1'b1) begin bad++; $display("FAIL ral got ac=%o l=%b want 0000/1", ac_out, l_out); end
        run_op(9'o010, 12'o0003, 1'b0, d, dn);
        total++; if (ac_out !== 12'o0001 || l_out !== 1'b1) begin bad++; $display("FAIL rar got ac=%o l=%b want 0001/1", ac_out, l_out); end
        run_op(9'o014, 12'o1234, 1'b1, d, dn);
        total++; if (ac_out !== 12'o1234 || l_out !== 1'b1) begin bad++; $display("FAIL rar_ral got ac=%o l=%b want 1234/1", ac_out, l_out); end
    endtask

    task automatic test_bsw();
        int d; logic dn;
        logic [11:0] exp_ac;
`ifdef OPR_BSW_EN
        exp_ac = 12'o3412;
`else
        exp_ac = 12'o1234;
`endif
        run_op(9'o002, 12'o1234, 1'b1, d, dn);
        total++; if (ac_out !== exp_ac) begin bad++; $display("FAIL bsw_ac got=%o want=%o", ac_out, exp_ac); end
        total++; if (l_out !== 1'b1) begin bad++; $display("FAIL bsw_l got=%b want=1", l_out); end
        total++; if (d !== 6) begin bad++; $display("FAIL bsw_latency got=%0d want=6", d); end
    endtask

    task automatic test_group2();
        int d; logic dn;
        run_op(9'o640, 12'o0000, 1'b0, d, dn);
        total++; if (skip !== 1'b1 || ac_out !== 12'o0000) begin bad++; $display("FAIL sza_cla got skip=%b ac=%o want 1/0000", skip, ac_out); end
        total++; if (d !== 3) begin bad++; $display("FAIL g2_latency got=%0d want=3", d); end
        total++; if (group !== 2'd2) begin bad++; $display("FAIL g2_group got=%0d want=2", group); end
        run_op(9'o640, 12'o0005, 1'b0, d, dn);
        total++; if (skip !== 1'b0 || ac_out !== 12'o0000) begin bad++; $display("FAIL sza_cla_nz got skip=%b ac=%o want 0/0000", skip, ac_out); end
        run_op(9'o450, 12'o0005, 1'b0, d, dn);
        total++; if (skip !== 1'b1 || ac_out !== 12'o0005) begin bad++; $display("FAIL sna got skip=%b ac=%o want 1/0005", skip, ac_out); end
        run_op(9'o510, 12'o4000, 1'b0, d, dn);
        total++; if (skip !== 1'b0) begin bad++; $display("FAIL spa got skip=%b want 0", skip); end
        run_op(9'o410, 12'o1234, 1'b0, d, dn);
        total++; if (skip !== 1'b1) begin bad++; $display("FAIL skp got skip=%b want 1", skip); end
        run_op(9'o420, 12'o1234, 1'b1, d, dn);
        total++; if (skip !== 1'b1 || l_out !== 1'b1) begin bad++; $display("FAIL snl got skip=%b l=%b want 1/1", skip, l_out); end
        run_op(9'o430, 12'o1234, 1'b1, d, dn);
        total++; if (skip !== 1'b0) begin bad++; $display("FAIL szl got skip=%b want 0", skip); end
    endtask

    task automatic test_group3();
        int d; logic dn;
        run_op(9'o601, 12'o1234, 1'b1, d, dn);
        total++; if (ac_out !== 12'o0000 || l_out !== 1'b1) begin bad++; $display("FAIL g3_cla got ac=%o l=%b want 0000/1", ac_out, l_out); end
        total++; if (d !== 2) begin bad++; $display("FAIL g3_latency got=%0d want=2", d); end
        total++; if (group !== 2'd3 || skip !== 1'b0) begin bad++; $display("FAIL g3_grp got grp=%0d skip=%b want 3/0", group, skip); end
        run_op(9'o577, 12'o1234, 1'b0, d, dn);
        total++; if (ac_out !== 12'o1234 || l_out !== 1'b0) begin bad++; $display("FAIL g3_nocla got ac=%o l=%b want 1234/0", ac_out, l_out); end
    endtask

    task automatic test_reset_abort();
        int d; logic dn;
        int ndone;
        i_reg = 9'o001;
        ac_in = 12'o7777;
        l_in  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got=%b want=1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_busy got busy=%b done=%b want 0/0", busy, done); end
        total++; if (ac_out !== 12'o0000 || group !== 2'd0) begin bad++; $display("FAIL abort_outs got ac=%o grp=%0d want 0000/0", ac_out, group); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_nodone got=%0d want=0", ndone); end
        run_op(9'o240, 12'o1234, 1'b0, d, dn);
        total++; if (ac_out !== 12'o7777 || d !== 6) begin bad++; $display("FAIL abort_restart got ac=%o cyc=%0d want 7777/6", ac_out, d); end
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        i_reg = 9'o440;
        ac_in = 12'o0000;
        l_in  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (k == 3 || k == 11) begin
                total++; if (done !== 1'b1 || skip !== 1'b1) begin bad++; $display("FAIL b2b_done%0d got done=%b skip=%b want 1/1", k, done, skip); end
            end
            if (k == 7) begin
                total++; if (done !== 1'b1 || skip !== 1'b0) begin bad++; $display("FAIL b2b_done7 got done=%b skip=%b want 1/0", done, skip); end
            end
            if (k == 4) begin
                total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b done=%b want 0/0", busy, done); end
            end
            if (k == 1) ac_in = 12'o0005;
            if (k == 7) ac_in = 12'o0000;
            if (k == 9) start = 1'b0;
        end
        total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", ndone); end
    endtask

    initial begin
        test_reset();
        test_group1_iac();
        test_rotate();
        test_bsw();
        test_group2();
        test_group3();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
